// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
// Encodings 7..10 only take effect when MD_MADD_EN is defined.
package md_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MADD    = 4'd7,
        MADDU   = 4'd8,
        MSUB    = 4'd9,
        MSUBU   = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_latency_ctr.sv
// Busy counter for multi-cycle MD ops: load N, stay busy N cycles, then
// flag the commit edge with done while the count reads 1.
module md_latency_ctr
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    output logic                busy,
    output logic                done,
    output md_state_e           state
);

    localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

    logic [MD_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_RUN;
                        count <= load_val;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done = (state == ST_RUN) && (count == CNT_ONE);

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding architectural HI/LO.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [MD_CNT_W-1:0] MULT_VAL = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_VAL  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           md_state;
    logic                accept, ctr_load, ctr_done;
    logic [MD_CNT_W-1:0] ctr_val;
    logic [63:0]         res;
    logic                res_wr, wr_hi, wr_lo;
    logic [31:0]         pending_hi, pending_lo;
    logic                pending_wr;
    logic [63:0]         ext_a_s, ext_b_s, prod_s, prod_u;
    logic [31:0]         div_b, quo_s, rem_s, quo_u, rem_u;

    // Handshake: an op is taken on a rising edge when start=1, flush=0 and the
    // unit is idle; start while busy is ignored (the hazard unit prevents it).
    assign accept = start && !flush && (md_state == ST_IDLE);

    assign ext_a_s = {{32{src_a[31]}}, src_a};
    assign ext_b_s = {{32{src_b[31]}}, src_b};
    assign prod_s  = ext_a_s * ext_b_s;
    assign prod_u  = {32'd0, src_a} * {32'd0, src_b};

    // A zero divisor is replaced so the dividers stay defined; the result is discarded.
    assign div_b = (src_b == 32'd0) ? 32'd1 : src_b;
    assign quo_s = 32'($signed(src_a) / $signed(div_b));
    assign rem_s = 32'($signed(src_a) % $signed(div_b));
    assign quo_u = src_a / div_b;
    assign rem_u = src_a % div_b;

    always_comb begin
        ctr_load = 1'b0;
        ctr_val  = '0;
        res      = '0;
        res_wr   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        if (accept) begin
            case (md_op_e'(md_op))
                MULT:  begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = prod_s; res_wr = 1'b1; end
                MULTU: begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = prod_u; res_wr = 1'b1; end
                DIV: begin
                    ctr_load = 1'b1; ctr_val = DIV_VAL;
                    res = {rem_s, quo_s}; res_wr = (src_b != 32'd0);
                end
                DIVU: begin
                    ctr_load = 1'b1; ctr_val = DIV_VAL;
                    res = {rem_u, quo_u}; res_wr = (src_b != 32'd0);
                end
                MTHI: wr_hi = 1'b1;
                MTLO: wr_lo = 1'b1;
`ifdef MD_MADD_EN
                MADD:  begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = {hi_out, lo_out} + prod_s; res_wr = 1'b1; end
                MADDU: begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = {hi_out, lo_out} + prod_u; res_wr = 1'b1; end
                MSUB:  begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = {hi_out, lo_out} - prod_s; res_wr = 1'b1; end
                MSUBU: begin ctr_load = 1'b1; ctr_val = MULT_VAL; res = {hi_out, lo_out} - prod_u; res_wr = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    md_latency_ctr u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_val),
        .busy     (busy),
        .done     (ctr_done),
        .state    (md_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out     <= '0;
            lo_out     <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_wr <= 1'b0;
        end else begin
            if (wr_hi) hi_out <= src_a;
            if (wr_lo) lo_out <= src_a;
            if (ctr_load) begin
                pending_hi <= res[63:32];
                pending_lo <= res[31:0];
                pending_wr <= res_wr;
            end
            // HI/LO only change at the commit edge; no bypass of pending results.
            if (ctr_done && pending_wr) begin
                hi_out <= pending_hi;
                lo_out <= pending_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences
// (flush, reset mid-op) and randomized ops against a reference model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy;
    logic [31:0] hi_out, lo_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] cur_hi, cur_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        int          exp_n;
    } vec_t;
    vec_t vecs[10];

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) assert (!(start && busy)) else $error("start asserted while busy");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: HI/LO after an accepted op and its busy length.
    task automatic md_model(input logic [3:0] op, input logic [31:0] a, b,
                            input logic [31:0] hi, lo,
                            output logic [31:0] nhi, nlo, output int n);
        logic [63:0] p, acc;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        nhi = hi; nlo = lo; n = 0;
        acc = {hi, lo};
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sb); {nhi, nlo} = p; n = MC; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {nhi, nlo} = p; n = MC; end
            4'd3: begin n = DC; if (b != 0) begin nlo = 32'(sa / sb); nhi = 32'(sa % sb); end end
            4'd4: begin n = DC; if (b != 0) begin nlo = a / b; nhi = a % b; end end
            4'd5: nhi = a;
            4'd6: nlo = a;
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (MADD_ON) begin
                    if (op == 4'd7 || op == 4'd9) p = longint'(sa) * longint'(sb);
                    else p = {32'd0, a} * {32'd0, b};
                    if (op <= 4'd8) {nhi, nlo} = acc + p;
                    else {nhi, nlo} = acc - p;
                    n = MC;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, b,
                          input logic [31:0] exp_hi, exp_lo, input int exp_n,
                          input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            check({tag, "_hold_hi"}, hi_out, cur_hi);
            check({tag, "_hold_lo"}, lo_out, cur_lo);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, ehi, elo;
        int          en;

        vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, MC};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[4] = '{4'd6, 32'd10, 32'd0, 32'hFFFFFFFF, 32'd10, 0};
        vecs[5] = '{4'd5, 32'd0, 32'd0, 32'd0, 32'd10, 0};
        vecs[6] = '{4'd11, 32'd5, 32'd5, 32'd0, 32'd10, 0};
        vecs[7] = '{4'd7, 32'd3, 32'd4, 32'd0, MADD_ON ? 32'd22 : 32'd10, MADD_ON ? MC : 0};
        vecs[8] = '{4'd9, 32'd5, 32'd10, MADD_ON ? 32'hFFFFFFFF : 32'd0,
                    MADD_ON ? 32'hFFFFFFE4 : 32'd10, MADD_ON ? MC : 0};
        vecs[9] = '{4'd0, 32'd1, 32'd1, MADD_ON ? 32'hFFFFFFFF : 32'd0,
                    MADD_ON ? 32'hFFFFFFE4 : 32'd10, 0};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        md_op = 4'd0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_n, $sformatf("vec%0d", i));

        // Flushed MTHI and MULT must not be accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = 4'd5; src_a = 32'h12345678;
        @(negedge clk);
        md_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
        check("flush_mthi_hi", hi_out, cur_hi);
        check("flush_mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_mult_busy", {31'd0, busy}, 32'd0);
        run_op(4'd5, 32'h12345678, 32'd0, 32'h12345678, cur_lo, 0, "mthi");

        // Reset during DIV aborts it: HI/LO clear and never get the late commit.
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi_out, 32'd0);
        check("abort_late_lo", lo_out, 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        for (int k = 0; k < 50; k++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            md_model(op, a, b, cur_hi, cur_lo, ehi, elo, en);
            run_op(op, a, b, ehi, elo, en, $sformatf("rnd%0d_op%0d", k, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
